// File: rtl/axi_stream_dw_upsizer.sv
// rtl/axi_stream_dw_upsizer.sv - packs Ratio narrow stream beats into one wide word, first beat in the lowest lane
// Optional idle flush of a partial word: define AXI_STREAM_DW_UPSIZER_TIMEOUT_EN.
module axi_stream_dw_upsizer #(
  parameter int DataWidthIn   = 8,
  parameter int DataWidthOut  = 32,
  parameter int IdWidth       = 1,
  parameter int DestWidth     = 1,
  parameter int UserWidth     = 1,
  parameter int TimeoutCycles = 16
) (
  input  logic                                                clk_i,
  input  logic                                                rst_i,
  input  logic [DataWidthIn-1:0]                              in_tdata,
  input  logic [DataWidthIn/8-1:0]                            in_tstrb,
  input  logic [DataWidthIn/8-1:0]                            in_tkeep,
  input  logic                                                in_tlast,
  input  logic [IdWidth-1:0]                                  in_tid,
  input  logic [DestWidth-1:0]                                in_tdest,
  input  logic [UserWidth-1:0]                                in_tuser,
  input  logic                                                in_tvalid,
  output logic                                                in_tready,
  output logic [DataWidthOut-1:0]                             out_tdata,
  output logic [DataWidthOut/8-1:0]                           out_tstrb,
  output logic [DataWidthOut/8-1:0]                           out_tkeep,
  output logic                                                out_tlast,
  output logic [IdWidth-1:0]                                  out_tid,
  output logic [DestWidth-1:0]                                out_tdest,
  output logic [UserWidth*(DataWidthOut/DataWidthIn)-1:0]     out_tuser,
  output logic                                                out_tvalid,
  input  logic                                                out_tready
);

  localparam int Ratio   = DataWidthOut / DataWidthIn;
  localparam int BytesIn = DataWidthIn / 8;
  localparam int CntW    = (Ratio > 1) ? $clog2(Ratio) : 1;
  localparam logic [CntW-1:0] LastLane = CntW'(Ratio - 1);

  if ((DataWidthIn % 8) != 0 || (DataWidthOut % DataWidthIn) != 0 || Ratio < 2 ||
      IdWidth < 1 || DestWidth < 1 || UserWidth < 1 || TimeoutCycles < 1) begin : g_bad_params
    $error("axi_stream_dw_upsizer: illegal parameter combination");
  end

  typedef enum logic {FILL, HOLD} state_e;

  state_e                          state_q;
  logic [CntW-1:0]                 cnt_q;
  logic [DataWidthOut-1:0]         data_q;
  logic [DataWidthOut/8-1:0]       strb_q;
  logic [DataWidthOut/8-1:0]       keep_q;
  logic [UserWidth*Ratio-1:0]      user_q;
  logic [IdWidth-1:0]              tid_q;
  logic [DestWidth-1:0]            tdest_q;
  logic                            last_q;

  logic id_change;
  logic in_hs;
  logic timeout_hit;

  // A beat from a different tid/tdest may not join a started word; stall it and flush.
  assign id_change = (state_q == FILL) && (cnt_q != '0) && in_tvalid &&
                     ((in_tid != tid_q) || (in_tdest != tdest_q));

  always_comb begin
    in_tready = 1'b0;
    if (!rst_i) begin
      in_tready = (state_q == HOLD) ? out_tready : !id_change;
    end
  end

  assign in_hs = in_tvalid && in_tready;

`ifdef AXI_STREAM_DW_UPSIZER_TIMEOUT_EN
  localparam int IdleW = $clog2(TimeoutCycles + 1);
  logic [IdleW-1:0] idle_q;

  assign timeout_hit = (state_q == FILL) && (cnt_q != '0) && !in_hs &&
                       (idle_q == IdleW'(TimeoutCycles - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i || in_hs || (state_q != FILL) || (cnt_q == '0) || timeout_hit) begin
      idle_q <= '0;
    end else begin
      idle_q <= idle_q + 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= FILL;
      cnt_q   <= '0;
      data_q  <= '0;
      strb_q  <= '0;
      keep_q  <= '0;
      user_q  <= '0;
      tid_q   <= '0;
      tdest_q <= '0;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        FILL: begin
          if (in_hs) begin
            for (int i = 0; i < Ratio; i++) begin
              if (cnt_q == CntW'(i)) begin
                data_q[i*DataWidthIn +: DataWidthIn] <= in_tdata;
                strb_q[i*BytesIn +: BytesIn]         <= in_tstrb;
                keep_q[i*BytesIn +: BytesIn]         <= in_tkeep;
                user_q[i*UserWidth +: UserWidth]     <= in_tuser;
              end
            end
            if (cnt_q == '0) begin
              tid_q   <= in_tid;
              tdest_q <= in_tdest;
            end
            if (cnt_q == LastLane || in_tlast) begin
              state_q <= HOLD;
              cnt_q   <= '0;
              last_q  <= in_tlast;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (id_change || timeout_hit) begin
            state_q <= HOLD;
            cnt_q   <= '0;
            last_q  <= 1'b0;
          end
        end
        HOLD: begin
          if (out_tready) begin
            // Word leaves; unfilled lanes of the next word must read as zero.
            state_q <= FILL;
            cnt_q   <= '0;
            data_q  <= '0;
            strb_q  <= '0;
            keep_q  <= '0;
            user_q  <= '0;
            last_q  <= 1'b0;
            if (in_hs) begin
              data_q[DataWidthIn-1:0] <= in_tdata;
              strb_q[BytesIn-1:0]     <= in_tstrb;
              keep_q[BytesIn-1:0]     <= in_tkeep;
              user_q[UserWidth-1:0]   <= in_tuser;
              tid_q                   <= in_tid;
              tdest_q                 <= in_tdest;
              if (in_tlast) begin
                state_q <= HOLD;
                last_q  <= 1'b1;
              end else begin
                cnt_q <= CntW'(1);
              end
            end
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end

  assign out_tvalid = (state_q == HOLD);
  assign out_tdata  = data_q;
  assign out_tstrb  = strb_q;
  assign out_tkeep  = keep_q;
  assign out_tuser  = user_q;
  assign out_tid    = tid_q;
  assign out_tdest  = tdest_q;
  assign out_tlast  = last_q;

endmodule

// File: tb/tb_axi_stream_dw_upsizer.sv
// tb/tb_axi_stream_dw_upsizer.sv - directed cycle vectors for the 8->32 stream upsizer
// Build with AXI_STREAM_DW_UPSIZER_TIMEOUT_EN to exercise the idle flush.
module tb_axi_stream_dw_upsizer;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  in_tdata;
  logic [0:0]  in_tstrb, in_tkeep;
  logic        in_tlast;
  logic [0:0]  in_tid, in_tdest, in_tuser;
  logic        in_tvalid, in_tready;
  logic [31:0] out_tdata;
  logic [3:0]  out_tstrb, out_tkeep, out_tuser;
  logic        out_tlast;
  logic [0:0]  out_tid, out_tdest;
  logic        out_tvalid, out_tready;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  axi_stream_dw_upsizer dut (
    .clk_i(clk), .rst_i(rst),
    .in_tdata(in_tdata), .in_tstrb(in_tstrb), .in_tkeep(in_tkeep), .in_tlast(in_tlast),
    .in_tid(in_tid), .in_tdest(in_tdest), .in_tuser(in_tuser),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .out_tdata(out_tdata), .out_tstrb(out_tstrb), .out_tkeep(out_tkeep), .out_tlast(out_tlast),
    .out_tid(out_tid), .out_tdest(out_tdest), .out_tuser(out_tuser),
    .out_tvalid(out_tvalid), .out_tready(out_tready)
  );

  typedef struct {
    logic        v;
    logic [7:0]  d;
    logic        l;
    logic        id;
    logic        ordy;
    logic        eir;
    logic        eov;
    logic [31:0] ed;
    logic [3:0]  ek;
    logic        el;
    logic        eid;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic v, input logic [7:0] d, input logic l, input logic id, input logic ordy,
                     input logic eir, input logic eov, input logic [31:0] ed, input logic [3:0] ek,
                     input logic el, input logic eid);
    vec_t t;
    t.v = v; t.d = d; t.l = l; t.id = id; t.ordy = ordy;
    t.eir = eir; t.eov = eov; t.ed = ed; t.ek = ek; t.el = el; t.eid = eid;
    vecs.push_back(t);
  endtask

  // Drive one cycle, check in_tready before the edge and the registered outputs after it.
  task automatic step(input vec_t t, input string nm);
    logic [3:0] eu;
    @(negedge clk);
    in_tvalid  = t.v;
    in_tdata   = t.d;
    in_tlast   = t.l;
    in_tid     = t.id;
    in_tuser   = t.d[0];
    out_tready = t.ordy;
    #1;
    chk({nm, ".in_tready"}, {31'd0, in_tready}, {31'd0, t.eir});
    @(posedge clk);
    #1;
    chk({nm, ".out_tvalid"}, {31'd0, out_tvalid}, {31'd0, t.eov});
    if (t.eov) begin
      eu = {t.ed[24], t.ed[16], t.ed[8], t.ed[0]};
      chk({nm, ".out_tdata"}, out_tdata, t.ed);
      chk({nm, ".out_tkeep"}, {28'd0, out_tkeep}, {28'd0, t.ek});
      chk({nm, ".out_tstrb"}, {28'd0, out_tstrb}, {28'd0, t.ek});
      chk({nm, ".out_tlast"}, {31'd0, out_tlast}, {31'd0, t.el});
      chk({nm, ".out_tid"}, {31'd0, out_tid}, {31'd0, t.eid});
      chk({nm, ".out_tuser"}, {28'd0, out_tuser}, {28'd0, eu});
    end
  endtask

  task automatic beat(input logic [7:0] d, input logic l, input logic eov,
                      input logic [31:0] ed, input logic [3:0] ek, input logic el, input string nm);
    vec_t t;
    t.v = 1'b1; t.d = d; t.l = l; t.id = 1'b0; t.ordy = 1'b1;
    t.eir = 1'b1; t.eov = eov; t.ed = ed; t.ek = ek; t.el = el; t.eid = 1'b0;
    step(t, nm);
  endtask

  initial begin
    rst = 1'b1;
    in_tvalid = 1'b0; in_tdata = '0; in_tlast = 1'b0; in_tid = '0; in_tdest = '0;
    in_tuser = '0; in_tstrb = 1'b1; in_tkeep = 1'b1; out_tready = 1'b0;

    // Cycle-by-cycle table: v, d, l, id, ordy | in_tready, out_tvalid, data, keep, last, tid
    add(1, 8'hef, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h56, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h34, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h12, 1, 0, 1, 1, 1, 32'h123456ef, 4'hf, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'hef, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h56, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h34, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h12, 0, 0, 1, 1, 1, 32'h123456ef, 4'hf, 0, 0);
    add(1, 8'hef, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h56, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h34, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h12, 1, 0, 1, 1, 1, 32'h123456ef, 4'hf, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'haa, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'hbb, 1, 0, 1, 1, 1, 32'h0000bbaa, 4'h3, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h01, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h02, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h03, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h04, 0, 0, 1, 1, 1, 32'h04030201, 4'hf, 0, 0);
    for (int i = 0; i < 5; i++) add(1, 8'h05, 0, 0, 0, 0, 1, 32'h04030201, 4'hf, 0, 0);
    add(1, 8'h05, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h06, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h07, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h08, 1, 0, 1, 1, 1, 32'h08070605, 4'hf, 1, 0);
    add(0, 8'h00, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h11, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h22, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h33, 0, 1, 1, 0, 1, 32'h00002211, 4'h3, 0, 0);
    add(1, 8'h33, 0, 1, 1, 1, 0, 32'h0, 4'h0, 0, 0);
    add(1, 8'h44, 1, 1, 1, 1, 1, 32'h00004433, 4'h3, 1, 1);
    add(0, 8'h00, 0, 0, 1, 1, 0, 32'h0, 4'h0, 0, 0);

    // Reset state
    @(negedge clk);
    #1;
    chk("rst.in_tready", {31'd0, in_tready}, 32'd0);
    @(posedge clk);
    #1;
    chk("rst.out_tvalid", {31'd0, out_tvalid}, 32'd0);
    chk("rst.out_tdata", out_tdata, 32'd0);
    chk("rst.out_tkeep", {28'd0, out_tkeep}, 32'd0);
    chk("rst.out_tlast", {31'd0, out_tlast}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) step(vecs[i], $sformatf("vec%0d", i));

    // Reset mid-word drops the partial lanes
    beat(8'h77, 0, 0, 32'h0, 4'h0, 0, "rmid.b0");
    beat(8'h88, 0, 0, 32'h0, 4'h0, 0, "rmid.b1");
    @(negedge clk);
    in_tvalid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rmid.in_tready", {31'd0, in_tready}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    beat(8'h99, 1, 1, 32'h00000099, 4'h1, 1, "rmid.b2");
    beat(8'h00, 0, 0, 32'h0, 4'h0, 0, "rmid.drain_b0");
    @(negedge clk);
    in_tvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Single beat then idle: flush after 16 cycles only with the timeout built in
    beat(8'h5a, 0, 0, 32'h0, 4'h0, 0, "tmo.beat");
    in_tvalid = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      logic exp_v;
      @(posedge clk);
      #1;
`ifdef AXI_STREAM_DW_UPSIZER_TIMEOUT_EN
      exp_v = (k == 16);
`else
      exp_v = 1'b0;
`endif
      chk($sformatf("tmo.out_tvalid.c%0d", k), {31'd0, out_tvalid}, {31'd0, exp_v});
    end
`ifdef AXI_STREAM_DW_UPSIZER_TIMEOUT_EN
    chk("tmo.out_tdata", out_tdata, 32'h0000005a);
    chk("tmo.out_tkeep", {28'd0, out_tkeep}, 32'h1);
    chk("tmo.out_tlast", {31'd0, out_tlast}, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
